z80_io_responder: RTL and testbench
===================================

# z80_io_responder

I/O-space responder for the Z80 test SoC bus, the target-side counterpart to the Z80 core's I/O and interrupt-acknowledge cycles. Decodes a 4-port window in I/O space and serves reads/writes from a small register file. Inserts a programmable number of wait states on each hit and raises `_int`. Supplies a mode-2 interrupt vector during the M1+IORQ acknowledge cycle. Runs on `eclk` and samples the CPU `clk` level to find CPU clock edges.

## Interface
- PORT_BASE, 8'h10, base I/O port; bits [1:0] ignored, window is PORT_BASE[7:2],2'bxx
- WAIT_STATES, 1, CPU `clk` rising edges `_wait` is held low per hit (0..7)
- INT_VECTOR, 8'hE0, byte driven during interrupt acknowledge
- eclk  in  1  system clock; all state on posedge
- ereset  in  1  asynchronous, active-high reset
- clk  in  1  CPU clock level, sampled on eclk
- ab  in  8  low address byte (I/O port)
- cpu_do  in  8  data from CPU (CPU write data)
- _m1, _iorq, _rd, _wr  in  1 each  active-low CPU strobes
- ext_irq  in  1  level; sets IP every eclk while high
- db_drv  out  8  data toward CPU
- db_oe  out  1  high while db_drv must drive the CPU data bus
- _wait  out  1  active-low wait request
- _int  out  1  active-low interrupt request

## Operation
- Registers (offset = ab[1:0]): 0,1 scratch R/W. 2 CTRL: bit0 IE, others read 0. 3 STAT: bit0 IP, write 1 clears, others read 0.
- hit = !_iorq & _m1 & (ab[7:2]==PORT_BASE[7:2]) & (!_rd | !_wr).
- intack = !_iorq & !_m1.
- FSM states:
  - IDLE: on hit → WAIT (WAIT_STATES>0) or ACCESS. On intack → INTACK.
  - WAIT: `_wait`=0. Count CPU clk rises. After WAIT_STATES rises → ACCESS.
  - ACCESS: read drives the register. A write latches cpu_do into the register on the eclk where `_wr` deasserts (or `_iorq` deasserts, whichever is first). → IDLE when `_iorq` high.
  - INTACK: db_drv=INT_VECTOR, db_oe=1, IP cleared on entry. → IDLE when `_iorq` high.
- Read data is also driven during WAIT, so the bus is stable before `_wait` releases.
- `_int` = !(IE & IP).
- ext_irq setting IP and a W1C clear in the same eclk: set wins.
- `_iorq` deasserting in any state → IDLE on the next eclk. Counter clears, db_oe=0, `_wait`=1.
- Memory cycles (`_mreq` low) are never decoded; `_mreq` is not an input.

## Timing
- Reset values: db_drv=8'h00, db_oe=0, `_wait`=1, `_int`=1, all registers 8'h00, FSM IDLE, wait counter 0.
- ereset asserted mid-cycle: all outputs return to reset values immediately (asynchronous).
- Decode latency: db_oe and `_wait` change 1 eclk after the qualifying strobes are sampled low.
- Release latency: db_oe falls 1 eclk after `_iorq`/`_rd` is sampled high.
- CPU clock rise = clk & !clk_q, where clk_q is clk registered on eclk. WAIT lasts exactly WAIT_STATES such rises. `_wait` returns to 1 on the eclk following the last counted rise.
- WAIT_STATES=0: WAIT is skipped and `_wait` never asserts.
- Write commit: exactly one eclk per cycle. A write cycle stretched by waits commits once.

## Configuration
- Macro: Z80_IO_INTACK_EN.
- Defined: INTACK state, vector drive, and the `_int` output behave as above.
- Undefined:
  - `_int` is tied to 1.
  - intack is ignored; FSM stays IDLE and db_oe stays 0.
  - IE/IP bits still read and write normally.

## Structure
- Shared package `z80_bus_pkg`:
  - FSM state enum (IDLE, WAIT, ACCESS, INTACK).
  - Register offset constants REG_SCR0/REG_SCR1/REG_CTRL/REG_STAT.
  - Bit positions CTRL_IE, STAT_IP.
- Sub-module `z80_io_regfile`: 4×8 storage, W1C and set-priority logic, read mux. The FSM and strobe handling stay in the top module.

## Test plan
- Reset: ereset pulse → db_oe=0, `_wait`=1, `_int`=1; a read of every port 0x10–0x13 returns 8'h00.
- IO write 8'hA5 to 0x11, then IO read 0x11 → `_wait` low for exactly 1 clk rise per cycle; read returns 8'hA5, 0x10 still 8'h00.
- WAIT_STATES=3, read 0x12 → `_wait` low across 3 clk rises. db_oe high before `_wait` releases, falls 1 eclk after `_rd` high.
- Write 8'h01 to CTRL, pulse ext_irq → `_int`=0. Intack cycle → db_drv=8'hE0, db_oe=1, IP clears, `_int`=1 after the cycle.
- Write 8'h01 to STAT while ext_irq high → IP stays 1. Access to port 0x14 → no db_oe and no `_wait`.
- ereset asserted during WAIT → `_wait`=1 and db_oe=0 immediately. The next hit restarts with the full wait count.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared FSM state, register offsets and bit positions for the Z80 I/O responder
package z80_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        INTACK = 2'd3
    } io_state_t;

    localparam logic [1:0] REG_SCR0 = 2'd0;
    localparam logic [1:0] REG_SCR1 = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    localparam int CTRL_IE = 0;
    localparam int STAT_IP = 0;

endpackage

// File: rtl/z80_io_regfile.sv
// rtl/z80_io_regfile.sv - 4x8 register file (scratch, CTRL.IE, STAT.IP W1C); _int gated by Z80_IO_INTACK_EN
module z80_io_regfile
    import z80_bus_pkg::*;
(
    input  logic       eclk,    // system clock
    input  logic       ereset,  // asynchronous, active-high
    input  logic       we,      // one-cycle write commit
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic [1:0] raddr,
    input  logic       set_ip,  // level from ext_irq
    input  logic       clr_ip,  // interrupt acknowledge entry
    output logic [7:0] rdata,
    output logic       int_n    // active-low interrupt request
);

    logic [7:0] scr0;
    logic [7:0] scr1;
    logic       ie;
    logic       ip;
    logic       w1c;

    assign w1c = we && (waddr == REG_STAT) && wdata[STAT_IP];

    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            scr0 <= 8'h00;
            scr1 <= 8'h00;
            ie   <= 1'b0;
            ip   <= 1'b0;
        end else begin
            if (we && waddr == REG_SCR0) scr0 <= wdata;
            if (we && waddr == REG_SCR1) scr1 <= wdata;
            if (we && waddr == REG_CTRL) ie   <= wdata[CTRL_IE];
            // A pending source beats any clear landing in the same cycle.
            if (set_ip)              ip <= 1'b1;
            else if (w1c || clr_ip)  ip <= 1'b0;
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (raddr)
            REG_SCR0: rdata = scr0;
            REG_SCR1: rdata = scr1;
            REG_CTRL: rdata[CTRL_IE] = ie;
            REG_STAT: rdata[STAT_IP] = ip;
            default:  rdata = 8'h00;
        endcase
    end

`ifdef Z80_IO_INTACK_EN
    assign int_n = ~(ie & ip);
`else
    assign int_n = 1'b1;
`endif

endmodule

// File: rtl/z80_io_responder.sv
// rtl/z80_io_responder.sv - Z80 I/O-space responder with wait states and mode-2 vector; intack via Z80_IO_INTACK_EN
module z80_io_responder
    import z80_bus_pkg::*;
#(
    parameter logic [7:0]  PORT_BASE   = 8'h10,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [7:0]  INT_VECTOR  = 8'hE0
) (
    input  logic       eclk,     // system clock
    input  logic       ereset,   // asynchronous, active-high
    input  logic       clk,      // CPU clock level
    input  logic [7:0] ab,       // I/O port address
    input  logic [7:0] cpu_do,   // CPU write data
    input  logic       _m1,
    input  logic       _iorq,
    input  logic       _rd,
    input  logic       _wr,
    input  logic       ext_irq,
    output logic [7:0] db_drv,   // data toward CPU
    output logic       db_oe,
    output logic       _wait,
    output logic       _int
);

    localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

    io_state_t  state;
    logic       clk_q;
    logic [2:0] wait_cnt;
    logic [1:0] addr_q;
    logic       wr_pend;

    logic       cpu_rise;
    logic       hit;
    logic       intack;
    logic       we;
    logic       clr_ack;
    logic [1:0] raddr;
    logic [7:0] rdata;

    assign cpu_rise = clk & ~clk_q;
    assign hit      = ~_iorq & _m1 & (ab[7:2] == PORT_BASE[7:2]) & (~_rd | ~_wr);

`ifdef Z80_IO_INTACK_EN
    assign intack = ~_iorq & ~_m1;
`else
    assign intack = 1'b0;
`endif

    // Commit exactly once, on the first cycle the CPU drops either strobe.
    assign we      = (state == ACCESS) & wr_pend & (_wr | _iorq);
    assign clr_ack = (state == IDLE) & intack;
    // Address is live on the bus while idle; held from the hit afterwards.
    assign raddr   = (state == IDLE) ? ab[1:0] : addr_q;

    z80_io_regfile u_regfile (
        .eclk   (eclk),
        .ereset (ereset),
        .we     (we),
        .waddr  (addr_q),
        .wdata  (cpu_do),
        .raddr  (raddr),
        .set_ip (ext_irq),
        .clr_ip (clr_ack),
        .rdata  (rdata),
        .int_n  (_int)
    );

    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            state    <= IDLE;
            clk_q    <= 1'b0;
            wait_cnt <= 3'd0;
            addr_q   <= 2'd0;
            wr_pend  <= 1'b0;
            db_drv   <= 8'h00;
            db_oe    <= 1'b0;
            _wait    <= 1'b1;
        end else begin
            clk_q <= clk;
            if (_iorq) begin
                state    <= IDLE;
                wait_cnt <= 3'd0;
                wr_pend  <= 1'b0;
                db_drv   <= 8'h00;
                db_oe    <= 1'b0;
                _wait    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (hit) begin
                            addr_q   <= ab[1:0];
                            wr_pend  <= ~_wr;
                            db_drv   <= rdata;
                            db_oe    <= ~_rd;
                            wait_cnt <= 3'd0;
                            if (WAIT_STATES != 0) begin
                                state <= WAIT;
                                _wait <= 1'b0;
                            end else begin
                                state <= ACCESS;
                            end
                        end else if (intack) begin
                            state  <= INTACK;
                            db_drv <= INT_VECTOR;
                            db_oe  <= 1'b1;
                        end
                    end
                    WAIT: begin
                        // Keep read data on the bus so it is settled before _wait releases.
                        db_drv <= rdata;
                        db_oe  <= ~_rd;
                        if (cpu_rise) begin
                            if (wait_cnt == WS_LAST) begin
                                state    <= ACCESS;
                                _wait    <= 1'b1;
                                wait_cnt <= 3'd0;
                            end else begin
                                wait_cnt <= wait_cnt + 3'd1;
                            end
                        end
                    end
                    ACCESS: begin
                        db_drv <= rdata;
                        db_oe  <= ~_rd;
                        if (we) wr_pend <= 1'b0;
                    end
                    INTACK: begin
                        db_drv <= INT_VECTOR;
                        db_oe  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_z80_io_responder.sv
// tb/tb_z80_io_responder.sv - randomized model-checked bench for z80_io_responder (WAIT_STATES 1 and 3)
module tb_z80_io_responder;

`ifdef Z80_IO_INTACK_EN
    localparam bit INTACK_EN = 1'b1;
`else
    localparam bit INTACK_EN = 1'b0;
`endif

    localparam logic [7:0] BASE = 8'h10;
    localparam logic [7:0] VEC  = 8'hE0;
    localparam int K_RD  = 1;
    localparam int K_WR  = 2;
    localparam int K_ACK = 3;

    logic       eclk    = 1'b0;
    logic       ereset  = 1'b1;
    logic       clk     = 1'b0;
    logic [7:0] ab      = 8'h00;
    logic [7:0] cpu_do  = 8'h00;
    logic       _m1     = 1'b1;
    logic       _iorq   = 1'b1;
    logic       _rd     = 1'b1;
    logic       _wr     = 1'b1;
    logic       ext_irq = 1'b0;

    logic [7:0] db_drv_a, db_drv_b;
    logic       db_oe_a, db_oe_b, _wait_a, _wait_b, _int_a, _int_b;

    int errors = 0;
    int checks = 0;

    always #5 eclk = ~eclk;

    // CPU clock: one level change every two eclk periods.
    int ph = 0;
    always @(negedge eclk) begin
        ph = ph + 1;
        if (ph == 2) begin
            ph  = 0;
            clk = ~clk;
        end
    end

    z80_io_responder #(.PORT_BASE(BASE), .WAIT_STATES(1), .INT_VECTOR(VEC)) dut_a (
        .eclk(eclk), .ereset(ereset), .clk(clk), .ab(ab), .cpu_do(cpu_do),
        ._m1(_m1), ._iorq(_iorq), ._rd(_rd), ._wr(_wr), .ext_irq(ext_irq),
        .db_drv(db_drv_a), .db_oe(db_oe_a), ._wait(_wait_a), ._int(_int_a)
    );

    z80_io_responder #(.PORT_BASE(BASE), .WAIT_STATES(3), .INT_VECTOR(VEC)) dut_b (
        .eclk(eclk), .ereset(ereset), .clk(clk), .ab(ab), .cpu_do(cpu_do),
        ._m1(_m1), ._iorq(_iorq), ._rd(_rd), ._wr(_wr), .ext_irq(ext_irq),
        .db_drv(db_drv_b), .db_oe(db_oe_b), ._wait(_wait_b), ._int(_int_b)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Reference model: bus-cycle view of each responder.
    logic [7:0] m_reg [2][4];
    bit         m_act [2];
    int         m_kind[2];
    int         m_rises[2];
    bit         m_done[2];
    logic [1:0] m_addr[2];
    bit         e_oe[2], e_wait[2], e_int[2];
    logic [7:0] e_drv[2];

    bit         s_rst, s_clk, s_iorq, s_m1, s_rd, s_wr, s_ext, s_rise;
    logic [7:0] s_ab, s_do;
    bit         prev_clk = 1'b0;
    bit         last_wait[2] = '{1'b1, 1'b1};
    int         wl[2] = '{0, 0};
    logic       rel_oe = 1'b0;

    task automatic model_edge(input int d);
        bit commit, w1c, clr_ack;
        logic [7:0] rdv;
        commit = 0; w1c = 0; clr_ack = 0;
        if (s_rst) begin
            for (int i = 0; i < 4; i++) m_reg[d][i] = 8'h00;
            m_act[d] = 0; m_kind[d] = 0; m_rises[d] = 0; m_done[d] = 0; m_addr[d] = 2'd0;
            e_oe[d] = 0; e_wait[d] = 1; e_int[d] = 1; e_drv[d] = 8'h00;
            return;
        end
        if (!m_act[d]) begin
            if (!s_iorq && s_m1 && s_ab[7:2] == BASE[7:2] && (!s_rd || !s_wr)) begin
                m_act[d] = 1; m_kind[d] = !s_wr ? K_WR : K_RD;
                m_addr[d] = s_ab[1:0]; m_rises[d] = 0; m_done[d] = 0;
            end else if (INTACK_EN && !s_iorq && !s_m1) begin
                m_act[d] = 1; m_kind[d] = K_ACK; clr_ack = 1;
            end
        end else begin
            if (m_kind[d] == K_WR && !m_done[d] && m_rises[d] >= ws_of(d) && (s_wr || s_iorq))
                commit = 1;
            if (s_iorq) m_act[d] = 0;
            else if (m_kind[d] != K_ACK && s_rise && m_rises[d] < ws_of(d)) m_rises[d]++;
        end
        rdv = m_reg[d][m_addr[d]];
        if (commit) begin
            m_done[d] = 1;
            case (m_addr[d])
                2'd0, 2'd1: m_reg[d][m_addr[d]] = s_do;
                2'd2:       m_reg[d][2] = {7'b0, s_do[0]};
                default:    w1c = s_do[0];
            endcase
        end
        if (s_ext)               m_reg[d][3] = 8'h01;
        else if (w1c || clr_ack) m_reg[d][3] = 8'h00;
        e_wait[d] = !(m_act[d] && m_kind[d] != K_ACK && m_rises[d] < ws_of(d));
        e_oe[d]   = m_act[d] && (m_kind[d] == K_ACK || !s_rd);
        e_drv[d]  = (m_kind[d] == K_ACK) ? VEC : rdv;
        e_int[d]  = INTACK_EN ? !(m_reg[d][2][0] && m_reg[d][3][0]) : 1'b1;
    endtask

    always @(posedge eclk) begin
        s_rst = ereset; s_clk = clk; s_ab = ab; s_do = cpu_do; s_m1 = _m1;
        s_iorq = _iorq; s_rd = _rd; s_wr = _wr; s_ext = ext_irq;
        s_rise = s_clk && !prev_clk;
        if (!s_rst && s_rise) begin
            if (!last_wait[0]) wl[0]++;
            if (!last_wait[1]) wl[1]++;
        end
        prev_clk = s_rst ? 1'b0 : s_clk;
        model_edge(0);
        model_edge(1);
        #1;
        chk("oe_a", db_oe_a, e_oe[0]);
        chk("wait_a", _wait_a, e_wait[0]);
        chk("int_a", _int_a, e_int[0]);
        if (e_oe[0]) chk("drv_a", db_drv_a, e_drv[0]);
        chk("oe_b", db_oe_b, e_oe[1]);
        chk("wait_b", _wait_b, e_wait[1]);
        chk("int_b", _int_b, e_int[1]);
        if (e_oe[1]) chk("drv_b", db_drv_b, e_drv[1]);
        if (s_rst) chk("rst_drv_b", db_drv_b, 8'h00);
        if (!last_wait[1] && _wait_b) rel_oe = db_oe_b;
        last_wait[0] = _wait_a;
        last_wait[1] = _wait_b;
    end

    task automatic io_cycle(input bit is_wr, input logic [7:0] port, input logic [7:0] data,
                            input bit early, output logic [7:0] bus_s, output logic oe_s);
        @(negedge eclk);
        ab = port; cpu_do = data; _m1 = 1'b1; _iorq = 1'b0;
        if (is_wr) _wr = 1'b0; else _rd = 1'b0;
        repeat (16) @(negedge eclk);
        oe_s  = db_oe_b;
        bus_s = db_oe_b ? db_drv_b : 8'h00;
        if (early) begin
            _rd = 1'b1; _wr = 1'b1;
            @(negedge eclk);
            if (!is_wr) chk("rd_release_oe", db_oe_b, 8'h00);
        end
        _iorq = 1'b1; _rd = 1'b1; _wr = 1'b1;
        repeat (2) @(negedge eclk);
        cpu_do = 8'($urandom);
    endtask

    task automatic ack_cycle(output logic [7:0] bus_s, output logic oe_s);
        @(negedge eclk);
        _m1 = 1'b0; _iorq = 1'b0;
        repeat (4) @(negedge eclk);
        oe_s  = db_oe_b;
        bus_s = db_oe_b ? db_drv_b : 8'h00;
        _m1 = 1'b1; _iorq = 1'b1;
        repeat (2) @(negedge eclk);
    endtask

    logic [7:0] bus;
    logic       oe;

    initial begin
        repeat (3) @(negedge eclk);
        ereset = 1'b0;
        @(negedge eclk);
        chk("rst_oe_a", db_oe_a, 8'h00);
        chk("rst_wait_a", _wait_a, 8'h01);
        chk("rst_int_a", _int_a, 8'h01);
        chk("rst_oe_b", db_oe_b, 8'h00);
        chk("rst_wait_b", _wait_b, 8'h01);
        chk("rst_int_b", _int_b, 8'h01);
        for (int p = 0; p < 4; p++) begin
            io_cycle(1'b0, BASE + 8'(p), 8'h00, 1'b0, bus, oe);
            chk("rst_read", bus, 8'h00);
        end

        io_cycle(1'b1, 8'h11, 8'hA5, 1'b0, bus, oe);
        wl[0] = 0; wl[1] = 0; rel_oe = 1'b0;
        io_cycle(1'b0, 8'h11, 8'h00, 1'b1, bus, oe);
        chk("read_a5", bus, 8'hA5);
        chk("wait_rises_ws1", 8'(wl[0]), 8'd1);
        chk("wait_rises_ws3", 8'(wl[1]), 8'd3);
        chk("oe_before_release", rel_oe, 8'h01);
        io_cycle(1'b0, 8'h10, 8'h00, 1'b0, bus, oe);
        chk("scr0_still_zero", bus, 8'h00);

        io_cycle(1'b1, 8'h12, 8'h01, 1'b1, bus, oe);
        @(negedge eclk); ext_irq = 1'b1;
        @(negedge eclk); ext_irq = 1'b0;
        @(negedge eclk);
        chk("int_asserted", _int_b, INTACK_EN ? 8'h00 : 8'h01);
        ack_cycle(bus, oe);
        chk("ack_oe", oe, INTACK_EN ? 8'h01 : 8'h00);
        chk("ack_vector", bus, INTACK_EN ? VEC : 8'h00);
        chk("int_after_ack", _int_b, 8'h01);
        io_cycle(1'b0, 8'h13, 8'h00, 1'b0, bus, oe);
        chk("ip_after_ack", bus, INTACK_EN ? 8'h00 : 8'h01);

        ext_irq = 1'b1;
        io_cycle(1'b1, 8'h13, 8'h01, 1'b0, bus, oe);
        io_cycle(1'b0, 8'h13, 8'h00, 1'b0, bus, oe);
        chk("set_beats_w1c", bus, 8'h01);
        ext_irq = 1'b0;
        io_cycle(1'b1, 8'h13, 8'h01, 1'b1, bus, oe);
        io_cycle(1'b0, 8'h13, 8'h00, 1'b0, bus, oe);
        chk("w1c_clears", bus, 8'h00);

        wl[1] = 0;
        io_cycle(1'b0, 8'h14, 8'h00, 1'b0, bus, oe);
        chk("miss_no_oe", oe, 8'h00);
        chk("miss_no_wait", 8'(wl[1]), 8'd0);

        @(negedge eclk);
        ab = 8'h12; _iorq = 1'b0; _rd = 1'b0;
        for (int i = 0; i < 8 && _wait_b; i++) @(negedge eclk);
        chk("wait_entered", _wait_b, 8'h00);
        #2 ereset = 1'b1;
        #1;
        chk("async_rst_wait", _wait_b, 8'h01);
        chk("async_rst_oe", db_oe_b, 8'h00);
        chk("async_rst_oe_a", db_oe_a, 8'h00);
        @(negedge eclk); _iorq = 1'b1; _rd = 1'b1;
        @(negedge eclk); ereset = 1'b0;
        @(negedge eclk);
        wl[1] = 0;
        io_cycle(1'b0, 8'h12, 8'h00, 1'b0, bus, oe);
        chk("restart_full_wait", 8'(wl[1]), 8'd3);

        for (int t = 0; t < 60; t++) begin
            int kind, sel;
            logic [7:0] port;
            kind = $urandom_range(0, 9);
            sel  = $urandom_range(0, 5);
            port = (sel < 4) ? BASE + 8'(sel) : (sel == 4) ? 8'h14 : 8'($urandom);
            ext_irq = ($urandom_range(0, 5) == 0);
            if (kind <= 3)      io_cycle(1'b1, port, 8'($urandom), 1'($urandom), bus, oe);
            else if (kind <= 8) io_cycle(1'b0, port, 8'h00, 1'($urandom), bus, oe);
            else                ack_cycle(bus, oe);
            ext_irq = 1'b0;
        end

        repeat (4) @(negedge eclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
